// File: rtl/fp32_multiplier_hs.sv
// IEEE-754 single-precision multiplier with independent stb/ack handshakes
// on A, B and Z; denormal in/out, round-to-nearest-even, IEEE specials.
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   in_a, in_a_stb, in_a_ack operand A handshake
//   in_b, in_b_stb, in_b_ack operand B handshake
//   out_z, out_z_stb         product and its valid flag
//   out_z_ack                consumer accepts the product
// Parameter:
//   SEQ_MUL  0: single-cycle 24x24 product, 1: 24-cycle shift-add
module fp32_multiplier_hs #(
  parameter bit SEQ_MUL = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] in_a,
  input  logic        in_a_stb,
  output logic        in_a_ack,
  input  logic [31:0] in_b,
  input  logic        in_b_stb,
  output logic        in_b_ack,
  output logic [31:0] out_z,
  output logic        out_z_stb,
  input  logic        out_z_ack
);

  typedef enum logic [3:0] {
    GET_A   = 4'd0,
    GET_B   = 4'd1,
    UNPACK  = 4'd2,
    SPECIAL = 4'd3,
    NORM_A  = 4'd4,
    NORM_B  = 4'd5,
    MUL_0   = 4'd6,
    MUL_1   = 4'd7,
    NORM_1  = 4'd8,
    NORM_2  = 4'd9,
    ROUND   = 4'd10,
    PACK    = 4'd11,
    PUT_Z   = 4'd12
  } state_t;

  // Whole machine state; all-zero is the reset state (GET_A, outputs low).
  typedef struct packed {
    state_t      st;
    logic        a_ack;
    logic        b_ack;
    logic        z_stb;
    logic [31:0] z;
    logic [31:0] a;
    logic [31:0] b;
    logic [23:0] a_m;
    logic [23:0] b_m;
    logic [23:0] z_m;
    logic [9:0]  a_e;
    logic [9:0]  b_e;
    logic [9:0]  z_e;
    logic        a_s;
    logic        b_s;
    logic        z_s;
    logic        g;
    logic        r;
    logic        s;
    logic [47:0] p;
    logic [4:0]  cnt;
  } regs_t;

  // Exponents are held unbiased, 10-bit two's complement.
  localparam logic [9:0] E_BIAS = 10'd127;
  localparam logic [9:0] E_SPEC = 10'd128;
  localparam logic [9:0] E_ZERO = 10'h381;
  localparam logic [9:0] E_DMIN = 10'h382;

  localparam logic signed [9:0] E_MIN = -10'sd126;
  localparam logic signed [9:0] E_TOP = 10'sd127;

  regs_t q;
  regs_t n;

  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;
  logic [24:0] sum;
  logic [47:0] prod;
  logic        done;

  assign in_a_ack  = q.a_ack;
  assign in_b_ack  = q.b_ack;
  assign out_z     = q.z;
  assign out_z_stb = q.z_stb;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q <= '0;
    end else begin
      q <= n;
    end
  end

  always_comb begin
    a_nan  = (q.a_e == E_SPEC) && (q.a_m[22:0] != 23'd0);
    b_nan  = (q.b_e == E_SPEC) && (q.b_m[22:0] != 23'd0);
    a_inf  = (q.a_e == E_SPEC) && (q.a_m[22:0] == 23'd0);
    b_inf  = (q.b_e == E_SPEC) && (q.b_m[22:0] == 23'd0);
    a_zero = (q.a_e == E_ZERO) && (q.a_m[22:0] == 23'd0);
    b_zero = (q.b_e == E_ZERO) && (q.b_m[22:0] == 23'd0);
  end

  always_comb begin
    n    = q;
    sum  = 25'd0;
    prod = 48'd0;
    done = 1'b0;

    unique case (q.st)
      GET_A: begin
        n.a_ack = 1'b1;
        if (q.a_ack && in_a_stb) begin
          n.a     = in_a;
          n.a_ack = 1'b0;
          n.st    = GET_B;
        end
      end

      GET_B: begin
        n.b_ack = 1'b1;
        if (q.b_ack && in_b_stb) begin
          n.b     = in_b;
          n.b_ack = 1'b0;
          n.st    = UNPACK;
        end
      end

      UNPACK: begin
        n.a_m = {1'b0, q.a[22:0]};
        n.b_m = {1'b0, q.b[22:0]};
        n.a_e = {2'b00, q.a[30:23]} - E_BIAS;
        n.b_e = {2'b00, q.b[30:23]} - E_BIAS;
        n.a_s = q.a[31];
        n.b_s = q.b[31];
        n.st  = SPECIAL;
      end

      SPECIAL: begin
        if (a_nan || b_nan ||
            (a_inf && b_zero) || (b_inf && a_zero)) begin
          n.z     = 32'h7FC0_0000;
          n.z_stb = 1'b1;
          n.st    = PUT_Z;
        end else if (a_inf || b_inf) begin
          n.z     = {q.a_s ^ q.b_s, 8'hFF, 23'h0};
          n.z_stb = 1'b1;
          n.st    = PUT_Z;
        end else if (a_zero || b_zero) begin
          n.z     = {q.a_s ^ q.b_s, 31'h0};
          n.z_stb = 1'b1;
          n.st    = PUT_Z;
        end else begin
          if (q.a_e == E_ZERO) begin
            n.a_e = E_DMIN;
          end else begin
            n.a_m[23] = 1'b1;
          end
          if (q.b_e == E_ZERO) begin
            n.b_e = E_DMIN;
          end else begin
            n.b_m[23] = 1'b1;
          end
          n.st = NORM_A;
        end
      end

      // Normalise loops leave as soon as the updated value is done,
      // so a state costs one edge per step, and at least one edge.
      NORM_A: begin
        if (!q.a_m[23]) begin
          n.a_m = {q.a_m[22:0], 1'b0};
          n.a_e = q.a_e - 10'd1;
        end
        if (n.a_m[23]) begin
          n.st = NORM_B;
        end
      end

      NORM_B: begin
        if (!q.b_m[23]) begin
          n.b_m = {q.b_m[22:0], 1'b0};
          n.b_e = q.b_e - 10'd1;
        end
        if (n.b_m[23]) begin
          n.st = MUL_0;
        end
      end

      MUL_0: begin
        n.z_s = q.a_s ^ q.b_s;
        n.z_e = q.a_e + q.b_e + 10'd1;
        n.p   = 48'd0;
        n.cnt = 5'd0;
        n.st  = MUL_1;
      end

      // Shift-add keeps the running sum in p[47:24] and retires one
      // product bit into p[23:0] per cycle, consuming b_m LSB first.
      MUL_1: begin
        if (SEQ_MUL) begin
          sum   = {1'b0, q.p[47:24]} +
                  (q.b_m[0] ? {1'b0, q.a_m} : 25'd0);
          prod  = {sum, q.p[23:1]};
          n.b_m = {1'b0, q.b_m[23:1]};
          n.cnt = q.cnt + 5'd1;
          done  = (q.cnt == 5'd23);
        end else begin
          prod = 48'(q.a_m) * 48'(q.b_m);
          done = 1'b1;
        end
        n.p = prod;
        if (done) begin
          n.z_m = prod[47:24];
          n.g   = prod[23];
          n.r   = prod[22];
          n.s   = |prod[21:0];
          n.st  = NORM_1;
        end
      end

      NORM_1: begin
        if (!q.z_m[23] && ($signed(q.z_e) > E_MIN)) begin
          n.z_m = {q.z_m[22:0], q.g};
          n.g   = q.r;
          n.r   = 1'b0;
          n.z_e = q.z_e - 10'd1;
        end
        if (n.z_m[23] || !($signed(n.z_e) > E_MIN)) begin
          n.st = NORM_2;
        end
      end

      // Denormalise: shifted-out bits migrate guard -> round -> sticky.
      NORM_2: begin
        if ($signed(q.z_e) < E_MIN) begin
          n.z_m = {1'b0, q.z_m[23:1]};
          n.g   = q.z_m[0];
          n.r   = q.g;
          n.s   = q.s | q.r;
          n.z_e = q.z_e + 10'd1;
        end
        if (!($signed(n.z_e) < E_MIN)) begin
          n.st = ROUND;
        end
      end

      ROUND: begin
        if (q.g && (q.r || q.s || q.z_m[0])) begin
          n.z_m = q.z_m + 24'd1;
          if (q.z_m == 24'hFF_FFFF) begin
            n.z_m = 24'h80_0000;
            n.z_e = q.z_e + 10'd1;
          end
        end
        n.st = PACK;
      end

      PACK: begin
        n.z = {q.z_s, q.z_e[7:0] + 8'd127, q.z_m[22:0]};
        if (($signed(q.z_e) == E_MIN) && !q.z_m[23]) begin
          n.z[30:23] = 8'd0;
        end
        if ($signed(q.z_e) > E_TOP) begin
          n.z = {q.z_s, 8'hFF, 23'h0};
        end
        n.z_stb = 1'b1;
        n.st    = PUT_Z;
      end

      PUT_Z: begin
        if (q.z_stb && out_z_ack) begin
          n.z_stb = 1'b0;
          n.st    = GET_A;
        end
      end

      default: begin
        n.st = GET_A;
      end
    endcase
  end

endmodule

// File: tb/tb_fp32_multiplier_hs.sv
// Self-checking bench for fp32_multiplier_hs: both SEQ_MUL variants,
// table-driven vectors through a scoreboard plus hold/reset sequences.
module tb_fp32_multiplier_hs;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] in_a  [2];
  logic        a_stb [2];
  logic        a_ack [2];
  logic [31:0] in_b  [2];
  logic        b_stb [2];
  logic        b_ack [2];
  logic [31:0] out_z [2];
  logic        z_stb [2];
  logic        z_ack [2];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fp32_multiplier_hs #(.SEQ_MUL(g == 1)) u_dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_a      (in_a[g]),
      .in_a_stb  (a_stb[g]),
      .in_a_ack  (a_ack[g]),
      .in_b      (in_b[g]),
      .in_b_stb  (b_stb[g]),
      .in_b_ack  (b_ack[g]),
      .out_z     (out_z[g]),
      .out_z_stb (z_stb[g]),
      .out_z_ack (z_ack[g])
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vt [18];
  logic [31:0] sb [$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [31:0] a,
                      input logic [31:0] b, input string nm);
    int t;
    in_a[d]  = a;
    a_stb[d] = 1'b1;
    t = 0;
    while (!a_ack[d] && t < 50) begin
      @(negedge Clk);
      t++;
    end
    check({nm, "_a_wait"}, {31'd0, t < 50}, 32'd1);
    @(negedge Clk);
    a_stb[d] = 1'b0;
    check({nm, "_a_drop"}, {31'd0, a_ack[d]}, 32'd0);
    in_b[d]  = b;
    b_stb[d] = 1'b1;
    t = 0;
    while (!b_ack[d] && t < 50) begin
      @(negedge Clk);
      t++;
    end
    check({nm, "_b_wait"}, {31'd0, t < 50}, 32'd1);
    @(negedge Clk);
    b_stb[d] = 1'b0;
    check({nm, "_acks_low"}, {30'd0, a_ack[d], b_ack[d]}, 32'd0);
  endtask

  task automatic run_op(input int d, input vec_t v, input int hold);
    int          lat;
    int          elat;
    logic [31:0] expz;
    logic [31:0] held;
    sb.push_back(v.z);
    send(d, v.a, v.b, v.name);
    lat = 0;
    while (!z_stb[d] && lat < 400) begin
      @(negedge Clk);
      lat++;
    end
    check({v.name, "_stb"}, {31'd0, z_stb[d]}, 32'd1);
    if (v.lat >= 0) begin
      elat = (v.lat > 2 && d == 1) ? v.lat + 23 : v.lat;
      check({v.name, "_lat"}, lat, elat);
    end
    expz = sb.pop_front();
    check({v.name, "_z"}, out_z[d], expz);
    held = out_z[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check({v.name, "_hold_flags"},
            {29'd0, z_stb[d], a_ack[d], b_ack[d]}, 32'd4);
      check({v.name, "_hold_z"}, out_z[d], held);
    end
    z_ack[d] = 1'b1;
    @(negedge Clk);
    z_ack[d] = 1'b0;
    check({v.name, "_stb_fall"},
          {30'd0, z_stb[d], a_ack[d]}, 32'd0);
    check({v.name, "_z_keep"}, out_z[d], held);
    @(negedge Clk);
    check({v.name, "_a_rise"}, {31'd0, a_ack[d]}, 32'd1);
  endtask

  task automatic abort_op(input int d, input int edges);
    send(d, 32'h3FC0_0000, 32'h4000_0000, "abort");
    repeat (edges) @(negedge Clk);
    check("abort_no_stb", {31'd0, z_stb[d]}, 32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_rst_flags",
          {29'd0, a_ack[d], b_ack[d], z_stb[d]}, 32'd0);
    check("abort_rst_z", out_z[d], 32'd0);
    @(negedge Clk);
    check("abort_restart",
          {30'd0, a_ack[d], z_stb[d]}, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 10, "m1p5x2"};
    vt[1]  = '{32'hC0000000, 32'h3F000000, 32'hBF800000, -1, "neg2xhalf"};
    vt[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, -1, "sticky"};
    vt[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 2, "infx0"};
    vt[4]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 2, "infxneg"};
    vt[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, "nanx1"};
    vt[6]  = '{32'h80000000, 32'h40000000, 32'h80000000, 2, "negzero"};
    vt[7]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, -1, "ovf"};
    vt[8]  = '{32'h00800000, 32'h3F000000, 32'h00400000, -1, "minnorm"};
    vt[9]  = '{32'h00000001, 32'h3F000000, 32'h00000000, -1, "tie_even0"};
    vt[10] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, -1, "onexone"};
    vt[11] = '{32'h40400000, 32'h40400000, 32'h41100000, 10, "threexthree"};
    vt[12] = '{32'h00000003, 32'h3F000000, 32'h00000002, -1, "tie_even2"};
    vt[13] = '{32'hFFC00000, 32'h00000000, 32'h7FC00000, 2, "negnan"};
    vt[14] = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 2, "zeroxinf"};
    vt[15] = '{32'h3F800000, 32'h00000001, 32'h00000001, -1, "mindenorm"};
    vt[16] = '{32'h00400000, 32'h40800000, 32'h01000000, -1, "den2norm"};
    vt[17] = '{32'hC0400000, 32'hC0000000, 32'h40C00000, 10, "negxneg"};

    for (int d = 0; d < 2; d++) begin
      in_a[d]  = 32'd0;
      in_b[d]  = 32'd0;
      a_stb[d] = 1'b0;
      b_stb[d] = 1'b0;
      z_ack[d] = 1'b0;
    end

    repeat (2) @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_flags",
            {29'd0, a_ack[d], b_ack[d], z_stb[d]}, 32'd0);
      check("reset_z", out_z[d], 32'd0);
    end
    Rst = 1'b0;
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_a_rise", {31'd0, a_ack[d]}, 32'd1);
    end

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 18; i++) begin
        run_op(d, vt[i], 1);
      end
      run_op(d, vt[11], 5);
      abort_op(d, (d == 1) ? 12 : 5);
      run_op(d, vt[0], 1);
      run_op(d, vt[12], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
